// File: rtl/result_monitor_if.sv
// CPU write bus seen by the result monitor.
// Ports: adr/wdata/memwrite; master drives, slave observes.
interface result_monitor_if;
  logic [15:0] adr;
  logic [7:0]  wdata;
  logic        memwrite;

  modport master (
    output adr,
    output wdata,
    output memwrite
  );

  modport slave (
    input adr,
    input wdata,
    input memwrite
  );
endinterface

// File: rtl/result_monitor.sv
// Watches CPU writes for a result byte and issues a PASS/FAIL/NOWRITE verdict.
// Ports: ph2, resetb, bus (slave), result, result_valid, wr_count, cycles, done, pass, fail, nowrite.
module result_monitor #(
  parameter logic [15:0] RESULT_ADDR = 16'h0080,
  parameter logic [15:0] DONE_ADDR   = 16'h00FF,
  parameter logic [7:0]  EXPECTED    = 8'h1F,
  parameter logic [15:0] TIMEOUT     = 16'd190
) (
  input  logic                ph2,
  input  logic                resetb,
  result_monitor_if.slave     bus,
  output logic [7:0]          result,
  output logic                result_valid,
  output logic [7:0]          wr_count,
  output logic [15:0]         cycles,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                nowrite
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_EVAL,
    S_PASS,
    S_FAIL,
    S_NOWRITE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_result;
  logic        r_valid;
  logic [7:0]  r_count;
  logic [15:0] r_cycles;
  logic        r_done;
  logic        r_pass;
  logic        r_fail;
  logic        r_nowrite;

  logic        w_run;
  logic        w_cap;
  logic        w_done_wr;
  logic        w_tmo;
  logic        w_trig;

  assign w_run     = (r_state == S_RUN);
  assign w_cap     = w_run && bus.memwrite
                     && (bus.adr == RESULT_ADDR);
  assign w_done_wr = w_run && bus.memwrite
                     && (bus.adr == DONE_ADDR);
  // Fires on the edge where cycles steps to TIMEOUT.
  assign w_tmo     = w_run
                     && (r_cycles == TIMEOUT - 16'd1);
  assign w_trig    = w_done_wr || w_tmo;

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The EVAL decision reads the registered result, which
  // already holds any capture made on the trigger edge.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_RUN;
      S_RUN: begin
        if (w_trig) begin
          w_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!r_valid) begin
          w_next = S_NOWRITE;
        end else if (r_result == EXPECTED) begin
          w_next = S_PASS;
        end else begin
          w_next = S_FAIL;
        end
      end
      S_PASS:    w_next = S_PASS;
      S_FAIL:    w_next = S_FAIL;
      S_NOWRITE: w_next = S_NOWRITE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      r_result <= 8'h00;
      r_valid  <= 1'b0;
      r_count  <= 8'h00;
    end else if (w_cap) begin
      r_result <= bus.wdata;
      r_valid  <= 1'b1;
      if (r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      r_cycles <= 16'h0000;
    end else if (w_run && (r_cycles != 16'hFFFF)) begin
      r_cycles <= r_cycles + 16'd1;
    end
  end

  // Verdict flags are registered alongside the state so
  // they change on the same edge the state does.
  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_nowrite <= 1'b0;
    end else begin
      r_pass    <= (w_next == S_PASS);
      r_fail    <= (w_next == S_FAIL);
      r_nowrite <= (w_next == S_NOWRITE);
      r_done    <= (w_next == S_PASS)
                   || (w_next == S_FAIL)
                   || (w_next == S_NOWRITE);
    end
  end

  assign result       = r_result;
  assign result_valid = r_valid;
  assign wr_count     = r_count;
  assign cycles       = r_cycles;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign nowrite      = r_nowrite;

endmodule
